// File: rtl/idma_error_handler_mp_if.sv
// ---------------------------------------------------------------------------
// idma_error_handler_mp_if
// Bundles every non-clock signal of the multi-port iDMA error handler.
//   slave  : handler side (inputs *_i, outputs *_o)
//   master : backend/frontend/testbench side (directions mirrored)
// Groups: 1D request handshake, burst-address capture (r_/w_ addr+consume),
// datapath responses (r_dp_*, w_dp_*), 1D response (rsp_*), frontend error
// decision (eh_*), legalizer control, and status (err_count, busy flags).
// ---------------------------------------------------------------------------
interface idma_error_handler_mp_if #(
  parameter int NumRdPorts  = 2,
  parameter int AddrWidth   = 32,
  parameter int ErrCntWidth = 8
);
  localparam int PortW = (NumRdPorts > 1) ? $clog2(NumRdPorts) : 1;

  logic                            req_valid_i;
  logic                            req_ready_i;
  logic [NumRdPorts*AddrWidth-1:0] r_addr_i;
  logic [NumRdPorts-1:0]           r_consume_i;
  logic [AddrWidth-1:0]            w_addr_i;
  logic                            w_consume_i;
  logic [NumRdPorts-1:0]           r_dp_valid_i;
  logic [NumRdPorts-1:0]           r_dp_last_i;
  logic [NumRdPorts*2-1:0]         r_dp_resp_i;
  logic [NumRdPorts-1:0]           r_dp_ready_o;
  logic                            w_dp_valid_i;
  logic [1:0]                      w_dp_resp_i;
  logic                            w_dp_ready_o;
  logic                            w_last_burst_i;
  logic                            w_super_last_i;
  logic                            rsp_valid_o;
  logic                            rsp_ready_i;
  logic                            rsp_last_o;
  logic                            rsp_error_o;
  logic [1:0]                      rsp_cause_o;
  logic                            rsp_err_type_o;
  logic [PortW-1:0]                rsp_port_o;
  logic [AddrWidth-1:0]            rsp_addr_o;
  logic                            eh_valid_i;
  logic                            eh_abort_i;
  logic                            eh_ready_o;
  logic                            dp_busy_i;
  logic                            legalizer_flush_o;
  logic                            legalizer_kill_o;
  logic                            dp_poison_o;
  logic [ErrCntWidth-1:0]          err_count_o;
  logic                            fsm_busy_o;
  logic                            cnt_busy_o;

  modport slave (
    input  req_valid_i, req_ready_i, r_addr_i, r_consume_i, w_addr_i, w_consume_i,
           r_dp_valid_i, r_dp_last_i, r_dp_resp_i, w_dp_valid_i, w_dp_resp_i,
           w_last_burst_i, w_super_last_i, rsp_ready_i, eh_valid_i, eh_abort_i, dp_busy_i,
    output r_dp_ready_o, w_dp_ready_o, rsp_valid_o, rsp_last_o, rsp_error_o, rsp_cause_o,
           rsp_err_type_o, rsp_port_o, rsp_addr_o, eh_ready_o, legalizer_flush_o,
           legalizer_kill_o, dp_poison_o, err_count_o, fsm_busy_o, cnt_busy_o
  );

  modport master (
    output req_valid_i, req_ready_i, r_addr_i, r_consume_i, w_addr_i, w_consume_i,
           r_dp_valid_i, r_dp_last_i, r_dp_resp_i, w_dp_valid_i, w_dp_resp_i,
           w_last_burst_i, w_super_last_i, rsp_ready_i, eh_valid_i, eh_abort_i, dp_busy_i,
    input  r_dp_ready_o, w_dp_ready_o, rsp_valid_o, rsp_last_o, rsp_error_o, rsp_cause_o,
           rsp_err_type_o, rsp_port_o, rsp_addr_o, eh_ready_o, legalizer_flush_o,
           legalizer_kill_o, dp_poison_o, err_count_o, fsm_busy_o, cnt_busy_o
  );
endinterface

// File: rtl/idma_error_handler_mp.sv
// ---------------------------------------------------------------------------
// idma_error_handler_mp
// Policy-configurable error handler for an iDMA backend with NumRdPorts read
// managers and one write manager. Burst addresses are captured per port so a
// bus error can be reported with its address; the first error blocks the
// response path until a CONTINUE/ABORT decision (from the frontend, or
// internally when Policy != 0). An ABORT of the last outstanding transfer
// flushes and kills the legalizer and then emits the closing response.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : idma_error_handler_mp_if.slave (all handshakes and status)
// Policy: 0 = ask frontend, 1 = auto-CONTINUE, 2 = auto-ABORT.
// ---------------------------------------------------------------------------
module idma_error_handler_mp #(
  parameter int NumRdPorts    = 2,
  parameter int AddrWidth     = 32,
  parameter int MetaFifoDepth = 4,
  parameter int OutstWidth    = 4,
  parameter int ErrCntWidth   = 8,
  parameter int Policy        = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  idma_error_handler_mp_if.slave bus
);
  localparam int PortW   = (NumRdPorts > 1) ? $clog2(NumRdPorts) : 1;
  localparam int PtrW    = $clog2(MetaFifoDepth);
  localparam int NumFifo = NumRdPorts + 1;  // index NumRdPorts is the write FIFO

  typedef enum logic [2:0] {
    IDLE, WAIT, WAIT_LAST_W, LEG_FLUSH, EMIT_EXTRA_RSP
  } state_e;

  state_e                 r_state, w_next;
  logic [AddrWidth-1:0]   r_mem  [NumFifo][MetaFifoDepth];
  logic [PtrW:0]          r_wptr [NumFifo];
  logic [PtrW:0]          r_rptr [NumFifo];
  logic [AddrWidth-1:0]   w_head [NumFifo];
  logic [NumFifo-1:0]     w_push, w_pop, w_full, w_empty;
  logic [OutstWidth-1:0]  r_outst;
  logic [ErrCntWidth-1:0] r_err_cnt;

  logic [NumRdPorts-1:0]  w_r_ready, w_rd_sel;
  logic                   w_w_ready, w_rd_err, w_wr_err, w_decide, w_abort;
  logic                   w_rsp_valid, w_rsp_error, w_rsp_type, w_eh_ready, w_flush, w_kill;
  logic [1:0]             w_rsp_cause, w_rd_cause;
  logic [PortW-1:0]       w_rsp_port, w_rd_port;
  logic [AddrWidth-1:0]   w_rsp_addr, w_rd_addr;
  logic                   w_inc, w_dec;

  // ---- burst-address FIFOs ----
  always_comb begin
    for (int k = 0; k < NumRdPorts; k++) begin
      w_pop[k] = bus.r_dp_valid_i[k] & w_r_ready[k] & bus.r_dp_last_i[k];
    end
    w_pop[NumRdPorts]  = bus.w_dp_valid_i & w_w_ready;
    w_push             = {bus.w_consume_i, bus.r_consume_i};
  end

  for (genvar g = 0; g < NumFifo; g++) begin : g_fifo
    logic [AddrWidth-1:0] w_din;
    if (g < NumRdPorts) begin : g_rd
      assign w_din = bus.r_addr_i[g*AddrWidth +: AddrWidth];
    end else begin : g_wr
      assign w_din = bus.w_addr_i;
    end
    // Extra MSB on the pointers distinguishes full from empty.
    assign w_empty[g] = (r_wptr[g] == r_rptr[g]);
    assign w_full[g]  = (r_wptr[g][PtrW] != r_rptr[g][PtrW]) &&
                        (r_wptr[g][PtrW-1:0] == r_rptr[g][PtrW-1:0]);
    assign w_head[g]  = r_mem[g][r_rptr[g][PtrW-1:0]];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_wptr[g] <= '0;
        r_rptr[g] <= '0;
      end else begin
        if (w_push[g]) r_wptr[g] <= r_wptr[g] + 1'b1;
        if (w_pop[g])  r_rptr[g] <= r_rptr[g] + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push[g]) r_mem[g][r_wptr[g][PtrW-1:0]] <= w_din;
    end
  end

  // ---- error detection: lowest read port wins, write last ----
  always_comb begin
    w_rd_err   = 1'b0;
    w_rd_sel   = '0;
    w_rd_port  = '0;
    w_rd_cause = '0;
    w_rd_addr  = '0;
    for (int k = NumRdPorts - 1; k >= 0; k--) begin
      if (bus.r_dp_valid_i[k] && bus.r_dp_resp_i[2*k+1]) begin
        w_rd_err   = 1'b1;
        w_rd_sel   = '0;
        w_rd_sel[k] = 1'b1;
        w_rd_port  = PortW'(k);
        w_rd_cause = bus.r_dp_resp_i[2*k +: 2];
        w_rd_addr  = w_head[k];
      end
    end
  end

  assign w_wr_err = bus.w_dp_valid_i & bus.w_dp_resp_i[1];
  assign w_decide = (Policy == 0) ? bus.eh_valid_i : 1'b1;
  assign w_abort  = (Policy == 0) ? bus.eh_abort_i : (Policy == 2);

  // ---- FSM: state register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.rsp_ready_i) begin
          if (w_rd_err)      w_next = WAIT;
          else if (w_wr_err) w_next = bus.w_last_burst_i ? WAIT_LAST_W : WAIT;
        end
      end
      WAIT, WAIT_LAST_W: begin
        if (w_decide) begin
          // Aborting the only outstanding transfer needs the legalizer killed;
          // otherwise the abort behaves like a continue for this transfer.
          if (w_abort && r_outst == OutstWidth'(1)) w_next = LEG_FLUSH;
          else if (w_abort && r_outst == '0)        w_next = IDLE;
          else w_next = (r_state == WAIT_LAST_W) ? EMIT_EXTRA_RSP : IDLE;
        end
      end
      LEG_FLUSH:      if (!bus.dp_busy_i)  w_next = EMIT_EXTRA_RSP;
      EMIT_EXTRA_RSP: if (bus.rsp_ready_i) w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    w_r_ready   = '0;
    w_w_ready   = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_error = 1'b0;
    w_rsp_cause = '0;
    w_rsp_type  = 1'b0;
    w_rsp_port  = '0;
    w_rsp_addr  = '0;
    w_eh_ready  = 1'b0;
    w_flush     = 1'b0;
    w_kill      = 1'b0;
    case (r_state)
      IDLE: begin
        w_r_ready = {NumRdPorts{bus.rsp_ready_i}};
        w_w_ready = bus.rsp_ready_i;
        if (w_rd_err) begin
          w_r_ready   = w_rd_sel & {NumRdPorts{bus.rsp_ready_i}};
          w_w_ready   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_error = 1'b1;
          w_rsp_cause = w_rd_cause;
          w_rsp_port  = w_rd_port;
          w_rsp_addr  = w_rd_addr;
        end else if (w_wr_err) begin
          w_r_ready   = '0;
          w_rsp_valid = 1'b1;
          w_rsp_error = 1'b1;
          w_rsp_cause = bus.w_dp_resp_i;
          w_rsp_type  = 1'b1;
          w_rsp_addr  = w_head[NumRdPorts];
        end else if (bus.w_dp_valid_i && bus.w_last_burst_i) begin
          w_rsp_valid = 1'b1;
        end
      end
      WAIT, WAIT_LAST_W: w_eh_ready = (Policy == 0) && bus.eh_valid_i;
      LEG_FLUSH: begin
        w_flush   = 1'b1;
        w_r_ready = '1;
        w_w_ready = 1'b1;
        w_kill    = !bus.dp_busy_i;
      end
      EMIT_EXTRA_RSP: w_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ---- outstanding and error counters ----
  assign w_inc = bus.req_valid_i & bus.req_ready_i;
  assign w_dec = w_rsp_valid & bus.rsp_ready_i & ~w_rsp_error;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_inc && !w_dec)      r_outst <= r_outst + 1'b1;
      else if (w_dec && !w_inc) r_outst <= r_outst - 1'b1;
      if (w_rsp_valid && bus.rsp_ready_i && w_rsp_error && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NumFifo; k++) begin
        assert (!(w_push[k] && w_full[k]));
        assert (!(w_pop[k] && w_empty[k]));
      end
      assert (!(w_inc && !w_dec && (&r_outst)));
      assert (!(w_dec && !w_inc && r_outst == '0));
      assert (!((r_state == WAIT || r_state == WAIT_LAST_W) && w_decide && w_abort &&
                r_outst == '0));
    end
  end

  assign bus.r_dp_ready_o      = w_r_ready;
  assign bus.w_dp_ready_o      = w_w_ready;
  assign bus.rsp_valid_o       = w_rsp_valid;
  assign bus.rsp_last_o        = bus.w_super_last_i;
  assign bus.rsp_error_o       = w_rsp_error;
  assign bus.rsp_cause_o       = w_rsp_cause;
  assign bus.rsp_err_type_o    = w_rsp_type;
  assign bus.rsp_port_o        = w_rsp_port;
  assign bus.rsp_addr_o        = w_rsp_addr;
  assign bus.eh_ready_o        = w_eh_ready;
  assign bus.legalizer_flush_o = w_flush;
  assign bus.legalizer_kill_o  = w_kill;
  assign bus.dp_poison_o       = w_flush;
  assign bus.err_count_o       = r_err_cnt;
  assign bus.fsm_busy_o        = (r_state != IDLE);
  assign bus.cnt_busy_o        = (r_outst != '0);
endmodule
